// File: rtl/bcd_result_formatter.sv
// Sequential binary-to-BCD converter feeding the LCD driver.
// Uses a 16-iteration shift-add-3 engine with a start/busy/done handshake.
module bcd_result_formatter #(
  parameter bit TWOS_COMP = 1'b0,
  parameter int WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [19:0] bcd
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mag_q;
  logic [19:0]   work_q;
  logic [CW-1:0] count_q;
  logic          negPending_q;
  logic          done_q;
  logic          sign_q;
  logic [19:0]   bcd_q;

  logic [15:0]   magCapture;
  logic [19:0]   workAdj;
  logic [19:0]   workNext;
  logic [15:0]   magNext;
  logic          lastIter;

  // Magnitude as seen at the start edge; 0x8000 in two's complement becomes 32768.
  always_comb begin
    magCapture = {1'b0, value[14:0]};
    if (TWOS_COMP) begin
      magCapture = value[15] ? (~value + 16'd1) : value;
    end
  end

  always_comb begin
    workAdj = work_q;
    for (int i = 0; i < 5; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        workAdj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    {workNext, magNext} = {workAdj[18:0], mag_q, 1'b0};
  end

  assign lastIter = (state_q == CONV) && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (lastIter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CONV);
    done = done_q;
    sign = sign_q;
    bcd  = bcd_q;
  end

  // Zero is always reported positive, so the sign is qualified at capture time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q        <= '0;
      work_q       <= '0;
      count_q      <= '0;
      negPending_q <= 1'b0;
      done_q       <= 1'b0;
      sign_q       <= 1'b0;
      bcd_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mag_q        <= magCapture;
            negPending_q <= value[15] & (magCapture != 16'd0);
            work_q       <= '0;
            count_q      <= '0;
          end
        end
        CONV: begin
          work_q  <= workNext;
          mag_q   <= magNext;
          count_q <= count_q + CW'(1);
          if (lastIter) begin
            bcd_q  <= workNext;
            sign_q <= negPending_q;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_result_formatter.sv
// Self-checking bench: both encodings run side by side against a decimal reference model.
// Directed handshake/reset scenarios plus a randomized sweep.
module tb_bcd_result_formatter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;

  logic        busy0, done0, sign0;
  logic [19:0] bcd0;
  logic        busy1, done1, sign1;
  logic [19:0] bcd1;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int          remain  [2];
  logic        expDone [2];
  logic        expSign [2];
  logic [19:0] expBcd  [2];
  logic        pendSign[2];
  logic [19:0] pendBcd [2];

  bcd_result_formatter #(.TWOS_COMP(1'b0), .WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy0), .done(done0), .sign(sign0), .bcd(bcd0)
  );

  bcd_result_formatter #(.TWOS_COMP(1'b1), .WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy1), .done(done1), .sign(sign1), .bcd(bcd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: magnitude per encoding, then digit k = mag / 10^k % 10.
  function automatic void refConvert(input int mode, input logic [15:0] v,
                                     output logic s, output logic [19:0] d);
    int m;
    int p;
    if (mode == 1) m = v[15] ? (65536 - int'({16'd0, v})) : int'({16'd0, v});
    else           m = int'({17'd0, v[14:0]});
    s = v[15] && (m != 0);
    d = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      d[4*k +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] v);
    start = s;
    value = v;
  endtask

  // Model: a conversion occupies 16 edges after the start edge, results appear on the last.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        remain[m]  = 0;
        expDone[m] = 1'b0;
        expSign[m] = 1'b0;
        expBcd[m]  = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        expDone[m] = 1'b0;
        if (remain[m] == 0) begin
          if (start === 1'b1) begin
            refConvert(m, value, pendSign[m], pendBcd[m]);
            remain[m] = 16;
          end
        end else begin
          remain[m] = remain[m] - 1;
          if (remain[m] == 0) begin
            expBcd[m]  = pendBcd[m];
            expSign[m] = pendSign[m];
            expDone[m] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic digitsValid(input logic [19:0] d);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) if (d[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("busy0", {31'd0, busy0}, {31'd0, remain[0] != 0});
      checkOutput("done0", {31'd0, done0}, {31'd0, expDone[0]});
      checkOutput("sign0", {31'd0, sign0}, {31'd0, expSign[0]});
      checkOutput("bcd0",  {12'd0, bcd0},  {12'd0, expBcd[0]});
      checkOutput("digits0", {31'd0, digitsValid(bcd0)}, 32'd1);
      checkOutput("busy1", {31'd0, busy1}, {31'd0, remain[1] != 0});
      checkOutput("done1", {31'd0, done1}, {31'd0, expDone[1]});
      checkOutput("sign1", {31'd0, sign1}, {31'd0, expSign[1]});
      checkOutput("bcd1",  {12'd0, bcd1},  {12'd0, expBcd[1]});
      checkOutput("digits1", {31'd0, digitsValid(bcd1)}, 32'd1);
    end
  end

  // Caller must be just past a falling edge; returns at the falling edge showing done.
  task automatic startAndWait(input logic [15:0] v, output int latency, output int busyCycles);
    int cycles;
    applyStimulus(1'b1, v);
    cycles = 0;
    busyCycles = 0;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) applyStimulus(1'b0, v);
      if (done0 === 1'b1) break;
      if (busy0 === 1'b1) busyCycles++;
    end
    latency = cycles - 1;
    checkOutput("latency", latency, 16);
  endtask

  task automatic convert(input logic [15:0] v);
    int lat, bc;
    logic        s;
    logic [19:0] d;
    @(negedge clk);
    startAndWait(v, lat, bc);
    refConvert(0, v, s, d);
    checkOutput("ref_bcd0", {12'd0, bcd0}, {12'd0, d});
    checkOutput("ref_sign0", {31'd0, sign0}, {31'd0, s});
    refConvert(1, v, s, d);
    checkOutput("ref_bcd1", {12'd0, bcd1}, {12'd0, d});
    checkOutput("ref_sign1", {31'd0, sign1}, {31'd0, s});
  endtask

  initial begin
    int lat, bc, doneCnt;
    logic holdOk;
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy0 | busy1}, 32'd0);
    checkOutput("rst_done", {31'd0, done0 | done1}, 32'd0);
    checkOutput("rst_sign", {31'd0, sign0 | sign1}, 32'd0);
    checkOutput("rst_bcd",  {12'd0, bcd0 | bcd1}, 32'd0);
    rst_n = 1'b1;

    @(negedge clk);
    startAndWait(16'h0000, lat, bc);
    checkOutput("zero_busy_cycles", bc, 16);
    checkOutput("zero_bcd", {12'd0, bcd0}, 32'h00000);
    checkOutput("zero_sign", {31'd0, sign0}, 32'd0);

    // Hand-computed pins for the sign-magnitude instance.
    convert(16'h3039); checkOutput("sm_12345", {12'd0, bcd0}, 32'h12345);
    checkOutput("sm_12345_sign", {31'd0, sign0}, 32'd0);
    convert(16'h8009); checkOutput("sm_m9", {12'd0, bcd0}, 32'h00009);
    checkOutput("sm_m9_sign", {31'd0, sign0}, 32'd1);
    convert(16'h8000); checkOutput("sm_negzero", {12'd0, bcd0}, 32'h00000);
    checkOutput("sm_negzero_sign", {31'd0, sign0}, 32'd0);
    checkOutput("tc_8000", {12'd0, bcd1}, 32'h32768);
    checkOutput("tc_8000_sign", {31'd0, sign1}, 32'd1);
    convert(16'h7FFF); checkOutput("sm_max", {12'd0, bcd0}, 32'h32767);
    checkOutput("sm_max_sign", {31'd0, sign0}, 32'd0);

    // Hand-computed pins for the two's-complement instance.
    convert(16'hFFFF); checkOutput("tc_m1", {12'd0, bcd1}, 32'h00001);
    checkOutput("tc_m1_sign", {31'd0, sign1}, 32'd1);
    convert(16'hFF85); checkOutput("tc_m123", {12'd0, bcd1}, 32'h00123);
    checkOutput("tc_m123_sign", {31'd0, sign1}, 32'd1);

    // A second start while busy must be ignored.
    @(negedge clk);
    applyStimulus(1'b1, 16'h1111);
    doneCnt = 0;
    @(negedge clk); applyStimulus(1'b0, 16'h1111);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 16'h2222);
    @(negedge clk); applyStimulus(1'b0, 16'h2222);
    repeat (30) begin
      @(negedge clk);
      if (done0 === 1'b1) doneCnt++;
    end
    checkOutput("ignore_done_count", doneCnt, 1);
    checkOutput("ignore_bcd", {12'd0, bcd0}, 32'h04369);

    // Start accepted in the done cycle.
    convert(16'd100);
    startAndWait(16'd42, lat, bc);
    checkOutput("backtoback_bcd", {12'd0, bcd0}, 32'h00042);

    // Outputs hold while value wanders without start.
    convert(16'd777);
    holdOk = 1'b1;
    repeat (100) begin
      @(negedge clk);
      applyStimulus(1'b0, 16'($urandom));
      if (bcd0 !== 20'h00777 || sign0 !== 1'b0 || done0 !== 1'b0) holdOk = 1'b0;
    end
    checkOutput("hold_stable", {31'd0, holdOk}, 32'd1);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    applyStimulus(1'b1, 16'd9999);
    @(negedge clk); applyStimulus(1'b0, 16'd9999);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy0 | busy1}, 32'd0);
    checkOutput("abort_done", {31'd0, done0 | done1}, 32'd0);
    checkOutput("abort_sign", {31'd0, sign0 | sign1}, 32'd0);
    checkOutput("abort_bcd",  {12'd0, bcd0 | bcd1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 === 1'b1 || done1 === 1'b1) doneCnt++;
    end
    checkOutput("abort_no_done", doneCnt, 0);
    convert(16'd9999);
    checkOutput("after_abort_bcd", {12'd0, bcd0}, 32'h09999);

    for (int i = 0; i < 1000; i++) convert(16'($urandom));

    repeat (3) @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
